// File: rtl/ldpc_pkg.sv
// Shared LDPC check-node definitions: message widths, row limits, FSM states,
// accumulator payload and small arithmetic helpers.
package ldpc_pkg;

   localparam int unsigned MAG_W     = 5;
   localparam int unsigned LANES     = 4;
   localparam int unsigned MAX_BEATS = 6;
   localparam int unsigned IDX_W     = 5;
   localparam int unsigned DEG_W     = IDX_W + 1;
   localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);

   localparam logic [MAG_W-1:0] MAG_MAX = '1;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

   // Running row result; also the registered output payload.
   typedef struct packed {
      logic [MAG_W-1:0] min1;
      logic [MAG_W-1:0] min2;
      logic [IDX_W-1:0] idx;
      logic             sign;
      logic [DEG_W-1:0] deg;
      logic             err;
   } acc_t;

   localparam acc_t ACC_RST = '{min1: MAG_MAX, min2: MAG_MAX, idx: '0,
                                sign: 1'b0, deg: '0, err: 1'b0};

   function automatic logic [MAG_W-1:0] min_mag(input logic [MAG_W-1:0] a,
                                                input logic [MAG_W-1:0] b);
      return (b < a) ? b : a;
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/cnu_min_scheduler_if.sv
// Beat-in / result-out bus of the check-node min scheduler.
//  slave  : the scheduler (accepts beats, presents results)
//  master : the producer/consumer around it
interface cnu_min_scheduler_if;
   import ldpc_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*MAG_W-1:0] in_mag;
   logic [LANES-1:0]       in_sign;
   logic [LANES-1:0]       in_lane_en;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [MAG_W-1:0]       out_min1;
   logic [MAG_W-1:0]       out_min2;
   logic [IDX_W-1:0]       out_min1_idx;
   logic                   out_sign;
   logic [DEG_W-1:0]       out_deg;
   logic                   out_err;

   modport slave (
      input  in_valid, in_mag, in_sign, in_lane_en, in_last, out_ready,
      output in_ready, out_valid, out_min1, out_min2, out_min1_idx,
             out_sign, out_deg, out_err
   );

   modport master (
      output in_valid, in_mag, in_sign, in_lane_en, in_last, out_ready,
      input  in_ready, out_valid, out_min1, out_min2, out_min1_idx,
             out_sign, out_deg, out_err
   );
endinterface

// File: rtl/min_sum_tree_4.sv
// Combinational 4-input min-sum tree: smallest, second-smallest and lane index
// of the smallest. Ties resolve to the lower lane.
//  mag      in  4*MAG_W  lane k at [k*MAG_W +: MAG_W]
//  min1_c   out MAG_W    smallest magnitude
//  min2_c   out MAG_W    second-smallest magnitude
//  idx_c    out 2        lane of min1_c
module min_sum_tree_4
   import ldpc_pkg::*;
(
   input  logic [LANES*MAG_W-1:0] mag,
   output logic [MAG_W-1:0]       min1_c,
   output logic [MAG_W-1:0]       min2_c,
   output logic [1:0]             idx_c
);

   logic [MAG_W-1:0] v [LANES];
   logic [MAG_W-1:0] lo0, hi0, lo1, hi1;
   logic             i0, i1;

   always_comb begin : tree
      for (int k = 0; k < LANES; k++) v[k] = mag[k*MAG_W +: MAG_W];

      // First level: pairs (0,1) and (2,3); strict compares keep the lower lane on ties.
      if (v[1] < v[0]) begin lo0 = v[1]; hi0 = v[0]; i0 = 1'b1; end
      else             begin lo0 = v[0]; hi0 = v[1]; i0 = 1'b0; end
      if (v[3] < v[2]) begin lo1 = v[3]; hi1 = v[2]; i1 = 1'b1; end
      else             begin lo1 = v[2]; hi1 = v[3]; i1 = 1'b0; end

      // Second level: the losing pair's low competes with the winning pair's high.
      if (lo1 < lo0) begin
         min1_c = lo1;
         idx_c  = {1'b1, i1};
         min2_c = min_mag(lo0, hi1);
      end else begin
         min1_c = lo0;
         idx_c  = {1'b0, i0};
         min2_c = min_mag(lo1, hi0);
      end
   end

endmodule

// File: rtl/cnu_min_scheduler.sv
// Sequences one check-node row through the 4-input min-sum tree, merging each
// beat into running min1/min2/index/sign/degree registers and holding the row
// result until the consumer takes it.
//  clk, rst_n  clock, asynchronous active-low reset
//  bus (slave) in_* beat handshake with lane data; out_* registered row result
module cnu_min_scheduler
   import ldpc_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   cnu_min_scheduler_if.slave  bus
);

   state_e                 state_q, state_d;
   acc_t                   acc_q, acc_d, acc_base;
   logic [BEAT_W-1:0]      beat_q, beat_d, beat_base;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic [LANES*MAG_W-1:0] lane_mag;
   logic [MAG_W-1:0]       t1, t2;
   logic [1:0]             t_idx;
   logic                   accept;

   assign accept = bus.in_valid & in_ready_q;

   // Disabled lanes present max magnitude so they never win a compare.
   always_comb begin : lane_mask
      lane_mag = '1;
      for (int k = 0; k < LANES; k++) begin
         if (bus.in_lane_en[k]) lane_mag[k*MAG_W +: MAG_W] = bus.in_mag[k*MAG_W +: MAG_W];
      end
   end

   min_sum_tree_4 u_tree (
      .mag    (lane_mag),
      .min1_c (t1),
      .min2_c (t2),
      .idx_c  (t_idx)
   );

   // Next state, merge and handshake decode.
   always_comb begin : fsm_next
      state_d   = state_q;
      acc_d     = acc_q;
      beat_d    = beat_q;
      acc_base  = acc_q;
      beat_base = beat_q;

      // A row starting from IDLE ignores whatever the previous row left behind.
      if (state_q == IDLE) begin
         acc_base  = ACC_RST;
         beat_base = '0;
      end

      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               state_d = bus.in_last ? HOLD : ACCUM;
               acc_d   = acc_base;
               beat_d  = beat_base;
               if (beat_base == BEAT_W'(MAX_BEATS)) begin
                  acc_d.err = 1'b1;
               end else begin
                  beat_d = beat_base + BEAT_W'(1);
                  if (t1 < acc_base.min1) begin
                     acc_d.min1 = t1;
                     acc_d.idx  = IDX_W'({beat_base, t_idx});
                     acc_d.min2 = min_mag(acc_base.min1, t2);
                  end else begin
                     acc_d.min2 = min_mag(acc_base.min2, t1);
                  end
                  acc_d.sign = acc_base.sign ^ (^(bus.in_sign & bus.in_lane_en));
                  acc_d.deg  = acc_base.deg + DEG_W'(popcount4(bus.in_lane_en));
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d != HOLD);
      out_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin : regs
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= ACC_RST;
         beat_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         beat_q      <= beat_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_min1     = acc_q.min1;
   assign bus.out_min2     = acc_q.min2;
   assign bus.out_min1_idx = acc_q.idx;
   assign bus.out_sign     = acc_q.sign;
   assign bus.out_deg      = acc_q.deg;
   assign bus.out_err      = acc_q.err;

endmodule

// File: tb/tb_cnu_min_scheduler.sv
// Directed bench for cnu_min_scheduler with hand-computed row results.
module tb_cnu_min_scheduler;
   import ldpc_pkg::*;

   localparam int unsigned RES_W = 2*MAG_W + IDX_W + 1 + DEG_W + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   cnu_min_scheduler_if bus ();

   cnu_min_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [RES_W-1:0] obs();
      return {bus.out_min1, bus.out_min2, bus.out_min1_idx, bus.out_sign, bus.out_deg, bus.out_err};
   endfunction

   function automatic logic [RES_W-1:0] res(input int m1, input int m2, input int idx,
                                            input int s, input int deg, input int err);
      return {MAG_W'(m1), MAG_W'(m2), IDX_W'(idx), 1'(s), DEG_W'(deg), 1'(err)};
   endfunction

   // Drive one beat at the negedge and hold it until the accepting posedge.
   task automatic send_beat(input int m0, input int m1, input int m2, input int m3,
                            input logic [3:0] sg, input logic [3:0] en, input logic last);
      int budget = 0;
      @(negedge clk);
      bus.in_mag     = {MAG_W'(m3), MAG_W'(m2), MAG_W'(m1), MAG_W'(m0)};
      bus.in_sign    = sg;
      bus.in_lane_en = en;
      bus.in_last    = last;
      bus.in_valid   = 1'b1;
      while (bus.in_ready !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 20) begin
         n_tests++; n_fail++;
         $display("FAIL send_beat timeout: in_ready=%b, required 1", bus.in_ready);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic handshake();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_mag = '0; bus.in_sign = '0;
      bus.in_lane_en = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (obs() !== res(31, 31, 0, 0, 0, 0)) begin
         n_fail++; $display("FAIL reset_result: got %h, required %h", obs(), res(31, 31, 0, 0, 0, 0));
      end
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_single_beat();
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_pre_valid: out_valid=%b, required 0", bus.out_valid);
      end
      send_beat(7, 3, 9, 5, 4'b0011, 4'hF, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL single_latency: out_valid=%b, required 1", bus.out_valid);
      end
      n_tests++;
      if (obs() !== res(3, 5, 1, 0, 4, 0)) begin
         n_fail++; $display("FAIL single_result: got %h, required %h", obs(), res(3, 5, 1, 0, 4, 0));
      end
      handshake();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_release: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_multi_beat();
      send_beat(9, 8, 7, 6,   4'b0001, 4'hF, 1'b0);
      send_beat(5, 12, 2, 11, 4'b0110, 4'hF, 1'b0);
      send_beat(4, 4, 4, 4,   4'b0000, 4'hF, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || obs() !== res(2, 4, 6, 1, 12, 0)) begin
         n_fail++; $display("FAIL multi_result: valid=%b got %h, required %h", bus.out_valid, obs(), res(2, 4, 6, 1, 12, 0));
      end
      handshake();
   endtask

   task automatic test_partial();
      send_beat(6, 6, 6, 6, 4'b0000, 4'hF,    1'b0);
      send_beat(1, 0, 0, 0, 4'b1110, 4'b0001, 1'b1);
      n_tests++;
      if (obs() !== res(1, 6, 4, 0, 5, 0)) begin
         n_fail++; $display("FAIL partial_result: got %h, required %h", obs(), res(1, 6, 4, 0, 5, 0));
      end
      handshake();
   endtask

   task automatic test_empty_row();
      send_beat(0, 0, 0, 0, 4'hF, 4'b0000, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || obs() !== res(31, 31, 0, 0, 0, 0)) begin
         n_fail++; $display("FAIL empty_result: valid=%b got %h, required %h", bus.out_valid, obs(), res(31, 31, 0, 0, 0, 0));
      end
      handshake();
   endtask

   task automatic test_tie();
      send_beat(3, 3, 8, 8, 4'b0000, 4'hF, 1'b0);
      send_beat(3, 9, 9, 9, 4'b0000, 4'hF, 1'b1);
      n_tests++;
      if (obs() !== res(3, 3, 0, 0, 8, 0)) begin
         n_fail++; $display("FAIL tie_result: got %h, required %h", obs(), res(3, 3, 0, 0, 8, 0));
      end
      handshake();
   endtask

   task automatic test_backpressure();
      send_beat(10, 20, 30, 15, 4'b0000, 4'hF, 1'b1);
      // Next row's beat waits on the bus while the consumer stalls.
      @(negedge clk);
      bus.in_mag     = {MAG_W'(14), MAG_W'(13), MAG_W'(11), MAG_W'(12)};
      bus.in_sign    = 4'b0100;
      bus.in_lane_en = 4'hF;
      bus.in_last    = 1'b1;
      bus.in_valid   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || obs() !== res(10, 15, 0, 0, 4, 0)) begin
            n_fail++;
            $display("FAIL bp_stall_%0d: in_ready=%b out_valid=%b got %h, required 0/1 %h",
                     c, bus.in_ready, bus.out_valid, obs(), res(10, 15, 0, 0, 4, 0));
         end
      end
      @(negedge clk) bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_bubble: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b1 || obs() !== res(11, 12, 1, 1, 4, 0)) begin
         n_fail++; $display("FAIL bp_next_row: valid=%b got %h, required %h", bus.out_valid, obs(), res(11, 12, 1, 1, 4, 0));
      end
      handshake();
   endtask

   task automatic test_overflow();
      send_beat(20, 21, 22, 23, 4'b0000, 4'hF, 1'b0);
      send_beat(19, 25, 25, 25, 4'b0000, 4'hF, 1'b0);
      send_beat(30, 30, 30, 30, 4'b0000, 4'hF, 1'b0);
      send_beat(30, 18, 30, 30, 4'b0000, 4'hF, 1'b0);
      send_beat(17, 30, 30, 30, 4'b0000, 4'hF, 1'b0);
      send_beat(30, 30, 30, 16, 4'b0000, 4'hF, 1'b0);
      send_beat(0, 0, 0, 0,     4'b0001, 4'hF, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || obs() !== res(16, 17, 23, 0, 24, 1)) begin
         n_fail++; $display("FAIL overflow_result: valid=%b got %h, required %h", bus.out_valid, obs(), res(16, 17, 23, 0, 24, 1));
      end
      handshake();
   endtask

   task automatic test_reset_mid_row();
      send_beat(1, 1, 1, 1, 4'b1111, 4'hF, 1'b0);
      send_beat(1, 1, 1, 1, 4'b0001, 4'hF, 1'b0);
      @(negedge clk);
      bus.in_mag = '0; bus.in_lane_en = 4'hF; bus.in_last = 1'b0;
      bus.in_valid = 1'b1;
      #2 bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs() !== res(31, 31, 0, 0, 0, 0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrow_reset: got %h valid=%b ready=%b, required %h 0/1",
                  obs(), bus.out_valid, bus.in_ready, res(31, 31, 0, 0, 0, 0));
      end
      @(negedge clk) rst_n = 1'b1;
      send_beat(7, 3, 9, 5, 4'b0011, 4'hF, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || obs() !== res(3, 5, 1, 0, 4, 0)) begin
         n_fail++; $display("FAIL midrow_next_row: valid=%b got %h, required %h", bus.out_valid, obs(), res(3, 5, 1, 0, 4, 0));
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_multi_beat();
      test_partial();
      test_empty_row();
      test_tie();
      test_backpressure();
      test_overflow();
      test_reset_mid_row();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
